// File: rtl/axis_serial_adc_multich_pkg.sv
// Shared types and elaboration helpers for the multi-lane serial ADC capture block.
package adc_axis_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CONV  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_TAIL  = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    // Width of the channel index; a single lane still gets a 1-bit tuser.
    function automatic int ch_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    // True when one frame (conversion, shifting, tail and a full-rate drain) fits the period.
    function automatic bit frame_timing_ok(input int frame_clks, input int conv_clks,
                                           input int sclk_div, input int data_width,
                                           input int num_ch);
        return frame_clks >= conv_clks + 2 * sclk_div * (data_width + 1) + num_ch;
    endfunction

endpackage

// File: rtl/axis_serial_adc_multich_sclk_gen.sv
// SCLK divider: toggles every SCLK_DIV clk cycles while run is high, idles low otherwise.
// rise_pulse/fall_pulse flag the clk edge on which SCLK_PIN will change.
module sclk_gen #(
    parameter int SCLK_DIV = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic SCLK_PIN,
    output logic rise_pulse,
    output logic fall_pulse
);

    localparam int DW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;

    logic [DW-1:0] div_cnt_r;
    logic          term_s;

    assign term_s     = (div_cnt_r == DW'(SCLK_DIV - 1));
    assign rise_pulse = run && term_s && !SCLK_PIN;
    assign fall_pulse = run && term_s && SCLK_PIN;

    // Half-period counter and SCLK toggle; both held cleared while not running.
    always_ff @(posedge clk) begin
        if (reset || !run) begin
            div_cnt_r <= {DW{1'b0}};
            SCLK_PIN  <= 1'b0;
        end else if (term_s) begin
            div_cnt_r <= {DW{1'b0}};
            SCLK_PIN  <= ~SCLK_PIN;
        end else begin
            div_cnt_r <= div_cnt_r + DW'(1);
        end
    end

endmodule

// File: rtl/axis_serial_adc_multich.sv
// Multi-lane serial ADC capture: requests a conversion, clocks all lanes in on one shared
// SCLK, then emits one AXIS beat per lane (channel order, tlast on the final lane).
module axis_serial_adc_multich
    import adc_axis_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_CH     = 2,
    parameter int SCLK_DIV   = 10,
    parameter int CONV_CLKS  = 300,
    parameter int FRAME_CLKS = 1000,
    localparam int CH_W      = ch_width(NUM_CH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [NUM_CH-1:0]     miso,
    output logic                  ask_sample,
    output logic                  SCLK_PIN,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [CH_W-1:0]       m_axis_tuser,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  overrun
);

    localparam int TW = $clog2(FRAME_CLKS + 1);
    localparam int CW = $clog2(CONV_CLKS + 1);
    localparam int BW = $clog2(DATA_WIDTH + 1);

    if (!frame_timing_ok(FRAME_CLKS, CONV_CLKS, SCLK_DIV, DATA_WIDTH, NUM_CH)) begin : g_frame_timing_warn
        $warning("FRAME_CLKS too short for one capture; overrun will pulse every frame");
    end

    state_t                           state_r;
    logic [TW-1:0]                    timer_r;
    logic [CW-1:0]                    conv_cnt_r;
    logic [BW-1:0]                    bit_cnt_r;
    logic                             first_frame_r;
    logic                             ovr_seen_r;
    logic [NUM_CH-1:0][DATA_WIDTH-1:0] shreg_r;
    logic [NUM_CH-1:0][DATA_WIDTH-1:0] obuf_r;
    logic                             run_s;
    logic                             rise_s;
    logic                             fall_s;
    logic                             timer_sat_s;
    logic [CH_W-1:0]                  next_ch_s;

    assign run_s       = (state_r == ST_SHIFT) || (state_r == ST_TAIL);
    assign timer_sat_s = (timer_r == TW'(FRAME_CLKS - 1));
    assign next_ch_s   = m_axis_tuser + CH_W'(1);

    sclk_gen #(
        .SCLK_DIV (SCLK_DIV)
    ) u_sclk_gen (
        .clk        (clk),
        .reset      (reset),
        .run        (run_s),
        .SCLK_PIN   (SCLK_PIN),
        .rise_pulse (rise_s),
        .fall_pulse (fall_s)
    );

    // Per-lane shift registers, MSB first: sample on the edge that raises SCLK.
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg_r <= '0;
        end else if (rise_s) begin
            for (int k = 0; k < NUM_CH; k++) begin
                shreg_r[k] <= {shreg_r[k][DATA_WIDTH-2:0], miso[k]};
            end
        end
    end

    // Frame sequencer, frame timer, overrun detection and the AXIS output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            timer_r       <= {TW{1'b0}};
            conv_cnt_r    <= {CW{1'b0}};
            bit_cnt_r     <= {BW{1'b0}};
            first_frame_r <= 1'b1;
            ovr_seen_r    <= 1'b0;
            obuf_r        <= '0;
            ask_sample    <= 1'b0;
            m_axis_tdata  <= {DATA_WIDTH{1'b0}};
            m_axis_tuser  <= {CH_W{1'b0}};
            m_axis_tlast  <= 1'b0;
            m_axis_tvalid <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            timer_r <= timer_sat_s ? timer_r : timer_r + TW'(1);
            overrun <= 1'b0;
            // The slot is missed once the timer saturates outside IDLE; report it only once.
            if (timer_sat_s && (state_r != ST_IDLE) && !ovr_seen_r) begin
                overrun    <= 1'b1;
                ovr_seen_r <= 1'b1;
            end
            case (state_r)
                ST_IDLE: begin
                    if (enable && (first_frame_r || timer_sat_s)) begin
                        state_r       <= ST_CONV;
                        timer_r       <= {TW{1'b0}};
                        first_frame_r <= 1'b0;
                        ovr_seen_r    <= 1'b0;
                        conv_cnt_r    <= {CW{1'b0}};
                        ask_sample    <= 1'b1;
                    end
                end
                ST_CONV: begin
                    if (conv_cnt_r == CW'(CONV_CLKS - 1)) begin
                        ask_sample <= 1'b0;
                        conv_cnt_r <= {CW{1'b0}};
                        bit_cnt_r  <= {BW{1'b0}};
                        state_r    <= ST_SHIFT;
                    end else begin
                        conv_cnt_r <= conv_cnt_r + CW'(1);
                    end
                end
                ST_SHIFT: begin
                    if (rise_s) begin
                        if (bit_cnt_r == BW'(DATA_WIDTH - 1)) begin
                            bit_cnt_r <= {BW{1'b0}};
                            state_r   <= ST_TAIL;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + BW'(1);
                        end
                    end
                end
                ST_TAIL: begin
                    if (fall_s) begin
                        obuf_r  <= shreg_r;
                        state_r <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!m_axis_tvalid) begin
                        m_axis_tvalid <= 1'b1;
                        m_axis_tdata  <= obuf_r[0];
                        m_axis_tuser  <= {CH_W{1'b0}};
                        m_axis_tlast  <= (CH_W'(0) == CH_W'(NUM_CH - 1));
                    end else if (m_axis_tready) begin
                        if (m_axis_tlast) begin
                            m_axis_tvalid <= 1'b0;
                            m_axis_tlast  <= 1'b0;
                            state_r       <= ST_IDLE;
                        end else begin
                            m_axis_tdata <= obuf_r[next_ch_s];
                            m_axis_tuser <= next_ch_s;
                            m_axis_tlast <= (next_ch_s == CH_W'(NUM_CH - 1));
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_serial_adc_multich.sv
// Scoreboard bench: a behavioural ADC model supplies random words per frame and queues the
// beats they should produce; a negedge monitor checks beats, timing and hold behaviour.
`timescale 1ns/1ps
module tb_axis_serial_adc_multich;

    localparam int DW    = 16;
    localparam int NCH   = 2;
    localparam int CHW   = 1;
    localparam int SDIV  = 10;
    localparam int CONV  = 300;
    localparam int FRAME = 1000;

    logic           clk = 1'b0;
    logic           reset;
    logic           enable;
    logic [NCH-1:0] miso;
    logic           ask_sample;
    logic           SCLK_PIN;
    logic [DW-1:0]  m_axis_tdata;
    logic [CHW-1:0] m_axis_tuser;
    logic           m_axis_tlast;
    logic           m_axis_tvalid;
    logic           m_axis_tready;
    logic           overrun;

    axis_serial_adc_multich #(
        .DATA_WIDTH (DW),
        .NUM_CH     (NCH),
        .SCLK_DIV   (SDIV),
        .CONV_CLKS  (CONV),
        .FRAME_CLKS (FRAME)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .miso          (miso),
        .ask_sample    (ask_sample),
        .SCLK_PIN      (SCLK_PIN),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0]  data;
        logic [CHW-1:0] user;
        logic           last;
    } beat_t;

    beat_t sb_q[$];
    int    errors = 0;
    int    checks = 0;

    // Shared state between stimulus and monitor
    int spacing_mode = 1;  // 0: unchecked, 1: FRAME apart, 2: 2 cycles after last beat
    bit idle_watch   = 1'b0;
    int idle_bad     = 0;
    int ovr_cnt      = 0;
    bit fixed_first  = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit cond(input int which);
        case (which)
            0:       return ask_sample === 1'b1;
            1:       return m_axis_tvalid === 1'b1;
            2:       return SCLK_PIN === 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_until(input int which, input int budget, input string name);
        int n = 0;
        while (!cond(which) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (!cond(which)) begin
            errors++;
            $display("FAIL timeout %s: waited %0d cycles, limit %0d", name, n, budget);
        end
    endtask

    // Behavioural ADC: new words per conversion, next bit presented after every SCLK rise.
    initial begin
        logic [DW-1:0] words [NCH];
        int  bit_idx   = DW;
        bit  ask_prev  = 1'b0;
        bit  sclk_prev = 1'b0;
        beat_t b;
        miso = '0;
        forever begin
            @(posedge clk); #1;
            if (ask_sample === 1'b1 && !ask_prev) begin
                if (fixed_first) begin
                    words[0]    = 16'hA5C3;
                    words[1]    = 16'h0F0F;
                    fixed_first = 1'b0;
                end else begin
                    for (int k = 0; k < NCH; k++) words[k] = DW'($urandom);
                    if ($urandom_range(0, 3) == 0) words[1] = words[0];
                end
                for (int k = 0; k < NCH; k++) begin
                    b.data = words[k];
                    b.user = CHW'(k);
                    b.last = (k == NCH - 1);
                    sb_q.push_back(b);
                end
                bit_idx = 0;
            end
            if (SCLK_PIN === 1'b1 && !sclk_prev) bit_idx++;
            ask_prev  = (ask_sample === 1'b1);
            sclk_prev = (SCLK_PIN === 1'b1);
            for (int k = 0; k < NCH; k++)
                miso[k] = (bit_idx < DW) ? words[k][DW-1-bit_idx] : 1'b0;
        end
    end

    // Monitor: pops the scoreboard on handshakes and checks frame timing.
    initial begin
        int cyc = 0, last_start = 0, last_beat_cyc = 0, sclk_rises = 0, ask_hi = 0;
        bit have_last = 1'b0, hold_pending = 1'b0;
        bit ask_prev = 1'b0, sclk_prev = 1'b0, tvalid_prev = 1'b0, ovr_prev = 1'b0;
        logic [18:0] held;
        beat_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset !== 1'b0) begin
                have_last    = 1'b0;
                hold_pending = 1'b0;
                sclk_rises   = 0;
                ask_hi       = 0;
            end else begin
                if (hold_pending) begin
                    check("hold_stable", {m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast}, held);
                    hold_pending = 1'b0;
                end
                if (m_axis_tvalid && !m_axis_tready) begin
                    held         = {m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast};
                    hold_pending = 1'b1;
                end
                if (m_axis_tvalid && !tvalid_prev) check("sclk_rises", sclk_rises, 16);
                if (m_axis_tvalid && m_axis_tready) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL beat: unexpected beat tdata=%h tuser=%0d, none expected", m_axis_tdata, m_axis_tuser);
                    end else begin
                        e = sb_q.pop_front();
                        check("beat", {m_axis_tdata, m_axis_tuser, m_axis_tlast}, {e.data, e.user, e.last});
                        if (m_axis_tlast) last_beat_cyc = cyc;
                    end
                end
                if (SCLK_PIN && !sclk_prev) sclk_rises++;
                if (ask_sample && !ask_prev) begin
                    if (spacing_mode == 1 && have_last) begin
                        check("frame_spacing", cyc - last_start, FRAME);
                    end else if (spacing_mode == 2) begin
                        check("restart_after_drain", cyc - last_beat_cyc, 2);
                        spacing_mode = 1;
                    end
                    last_start = cyc;
                    have_last  = 1'b1;
                    ask_hi     = 0;
                    sclk_rises = 0;
                end
                if (ask_sample) ask_hi++;
                if (!ask_sample && ask_prev) check("ask_high_cycles", ask_hi, CONV);
                if (overrun) begin
                    ovr_cnt++;
                    check("overrun_width", ovr_prev, 0);
                end
                if (idle_watch && (ask_sample || SCLK_PIN)) idle_bad++;
            end
            ask_prev    = (ask_sample === 1'b1);
            sclk_prev   = (SCLK_PIN === 1'b1);
            tvalid_prev = (m_axis_tvalid === 1'b1);
            ovr_prev    = (overrun === 1'b1);
        end
    end

    // Stimulus sequence
    initial begin
        reset         = 1'b1;
        enable        = 1'b0;
        m_axis_tready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state", {ask_sample, SCLK_PIN, m_axis_tvalid, m_axis_tlast, overrun, m_axis_tdata, m_axis_tuser}, 0);
        @(posedge clk); #1;
        reset  = 1'b0;
        enable = 1'b1;

        // Fixed first frame, then free-running frames at full readiness
        repeat (4000) begin @(posedge clk); #1; end

        // 50-cycle stall during a drain
        wait_until(1, 1200, "tvalid_for_stall");
        m_axis_tready = 1'b0;
        repeat (50) begin @(posedge clk); #1; end
        m_axis_tready = 1'b1;
        repeat (2000) begin @(posedge clk); #1; end

        // Random back-pressure
        repeat (3000) begin
            @(posedge clk); #1;
            m_axis_tready = ($urandom_range(0, 1) == 1);
        end
        m_axis_tready = 1'b1;
        repeat (1000) begin @(posedge clk); #1; end
        check("no_overrun_yet", ovr_cnt, 0);

        // Long stall forces one missed slot
        wait_until(1, 1200, "tvalid_for_long_stall");
        m_axis_tready = 1'b0;
        spacing_mode  = 2;
        repeat (2000) begin @(posedge clk); #1; end
        m_axis_tready = 1'b1;
        wait_until(0, 20, "restart_after_overrun");
        repeat (2100) begin @(posedge clk); #1; end
        check("one_overrun", ovr_cnt, 1);

        // Reset in the middle of shifting
        wait_until(2, 1200, "sclk_for_reset");
        repeat (40) begin @(posedge clk); #1; end
        reset        = 1'b1;
        spacing_mode = 0;
        sb_q.delete();
        @(posedge clk);
        @(negedge clk);
        check("reset_mid_shift", {ask_sample, SCLK_PIN, m_axis_tvalid, m_axis_tlast, overrun, m_axis_tdata, m_axis_tuser}, 0);
        @(posedge clk); #1;
        reset        = 1'b0;
        spacing_mode = 1;
        repeat (1500) begin @(posedge clk); #1; end

        // Drop enable during a conversion
        wait_until(0, 1100, "ask_for_disable");
        enable = 1'b0;
        repeat (800) begin @(posedge clk); #1; end
        idle_watch = 1'b1;
        repeat (2000) begin @(posedge clk); #1; end
        check("idle_after_disable", idle_bad, 0);
        check("scoreboard_empty", sb_q.size(), 0);
        check("overrun_total", ovr_cnt, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
